imm_encoder: RTL
================

# imm_encoder

Sequential immediate encoder for the instruction-memory loader path. It accepts an instruction template, an ImmSel format code and a 32-bit immediate value over a valid/ready handshake, and range-checks the immediate for that format. Legal immediates are scattered into the RISC-V instruction bit positions and written to instruction memory at an auto-incrementing address. It is the inverse of the decode stage's immediate extension and uses the same ImmSel codes.

## Interface
- DATA_WIDTH, 32, instruction/immediate width (fixed RV32; other values unsupported)
- ADDR_WIDTH, 8, instruction-memory word-address width
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- ImmSel  in  3  format: 000 I-ALU, 100 I-load, 001 U, 010 S, 011 J, 111 B; 101/110 illegal
- ImmVal  in  DATA_WIDTH  immediate value in two's complement, as the decoder would produce it
- Base  in  DATA_WIDTH  instruction template (opcode, rd, rs1, rs2, funct); immediate bit positions ignored
- addr_load  in  1  load write-address counter from start_addr (honoured in IDLE only)
- start_addr  in  ADDR_WIDTH  counter load value
- wr_en  out  1  instruction-memory write strobe
- wr_addr  out  ADDR_WIDTH  write word address (the current counter)
- wr_data  out  DATA_WIDTH  encoded instruction
- err  out  1  one-cycle pulse: request rejected
- err_count  out  8  saturating count of rejected requests

## Operation
- FSM states: IDLE, ENCODE, WRITE, FAULT.
- IDLE: in_ready=1. On in_valid, latch ImmSel, ImmVal and Base, then go to ENCODE.
  - addr_load in IDLE loads the counter.
  - If addr_load and an accept occur in the same cycle, both happen; the word is written at start_addr.
- ENCODE: in_ready=0. Check the range, build wr_data into a register, then go to WRITE if legal, else FAULT.
- Range rules (legal when):
  - I (000/100) and S: ImmVal[31:11] all equal.
  - U: ImmVal[11:0]==0.
  - B: ImmVal[0]==0 and ImmVal[31:12] all equal.
  - J: ImmVal[0]==0 and ImmVal[31:20] all equal.
  - 101/110: always illegal.
- Bit placement. Start from Base and overwrite only the listed fields:
  - I: [31:20]=imm[11:0].
  - U: [31:12]=imm[31:12].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- WRITE: wr_en=1 for exactly one cycle with wr_addr=counter. The counter then increments and the FSM returns to IDLE.
- Counter arithmetic: modulo 2^ADDR_WIDTH; after all-ones it wraps to 0 silently.
- FAULT: err=1 for one cycle; err_count increments and saturates at 255. No write occurs and the counter is unchanged. Return to IDLE.
- Outputs are Moore-style: decoded from state and registers only, with no combinational path from inputs.

## Timing
- Reset values: state IDLE, in_ready=1, wr_en=0, wr_addr=0, wr_data=0, err=0, err_count=0, counter=0.
- Latency: accept on edge E0; ENCODE during the cycle after E0; WRITE or FAULT during the next cycle; in_ready high again the cycle after that.
- Throughput: one request per 3 cycles.
- wr_data holds its last encoded value outside WRITE. Only wr_en qualifies it.
- Inputs are sampled only on the accept edge. Changes while in_ready=0 are ignored.
- addr_load outside IDLE is ignored.
- rst asserted in any state takes effect on the next edge:
  - Any in-flight request is dropped and no write or err is issued.
  - err_count and the counter are cleared.

## Test plan
- Reset, then I-type: start_addr=0x10 with addr_load, Base=0x00000013, ImmSel=000, ImmVal=0xFFFFF800 -> wr_en pulse 2 cycles after accept, wr_addr=0x10, wr_data=0x80000013; next accept writes to 0x11.
- B-type: Base=0x00208063, ImmSel=111, ImmVal=0xFFFFFFFE -> wr_data=0xFE208FE3. Decode-stage extension of wr_data returns 0xFFFFFFFE. Repeat the round-trip check for random legal values in all five formats.
- Range faults: B with ImmVal=0x00001000; U with ImmVal=0x00000001; ImmSel=101 -> err pulse each time, no wr_en, err_count=3, counter unchanged.
- Wrap: load start_addr=0xFF and write a legal word -> wr_addr=0xFF; next write -> wr_addr=0x00.
- Handshake: hold in_valid high with changing data for 6 cycles -> exactly 2 accepts, each at an in_ready=1 edge, and each write carries the data captured at its accept.
- Reset mid-operation: assert rst during ENCODE -> no wr_en or err follows; outputs at reset values; err_count=0. Drive 256 faults -> err_count holds at 255.

Source files
------------

// File: rtl/imm_encoder.sv
// Sequential RV32 immediate encoder: range-checks an immediate for its ImmSel
// format, scatters it into an instruction template and writes it to imem.
module imm_encoder #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            ImmSel,
   input  logic [DATA_WIDTH-1:0] ImmVal,
   input  logic [DATA_WIDTH-1:0] Base,
   input  logic                  addr_load,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  err,
   output logic [7:0]            err_count
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ENCODE = 2'd1,
      WRITE  = 2'd2,
      FAULT  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [2:0]            sel_q, sel_d;
   logic [DATA_WIDTH-1:0] imm_q, imm_d;
   logic [DATA_WIDTH-1:0] base_q, base_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [7:0]            errcnt_q, errcnt_d;

   logic                  legal;
   logic [DATA_WIDTH-1:0] enc;
   logic                  hi11_same, hi12_same, hi20_same;

   // A field fits when every bit above its top is a copy of the sign
   assign hi11_same = (&imm_q[31:11]) | ~(|imm_q[31:11]);
   assign hi12_same = (&imm_q[31:12]) | ~(|imm_q[31:12]);
   assign hi20_same = (&imm_q[31:20]) | ~(|imm_q[31:20]);

   always_comb begin
      enc   = base_q;
      legal = 1'b0;
      case (sel_q)
         3'b000, 3'b100: begin
            legal      = hi11_same;
            enc[31:20] = imm_q[11:0];
         end
         3'b001: begin
            legal      = (imm_q[11:0] == 12'd0);
            enc[31:12] = imm_q[31:12];
         end
         3'b010: begin
            legal      = hi11_same;
            enc[31:25] = imm_q[11:5];
            enc[11:7]  = imm_q[4:0];
         end
         3'b111: begin
            legal      = ~imm_q[0] & hi12_same;
            enc[31]    = imm_q[12];
            enc[30:25] = imm_q[10:5];
            enc[11:8]  = imm_q[4:1];
            enc[7]     = imm_q[11];
         end
         3'b011: begin
            legal      = ~imm_q[0] & hi20_same;
            enc[31]    = imm_q[20];
            enc[30:21] = imm_q[10:1];
            enc[20]    = imm_q[11];
            enc[19:12] = imm_q[19:12];
         end
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      imm_d    = imm_q;
      base_d   = base_q;
      data_d   = data_q;
      cnt_d    = cnt_q;
      errcnt_d = errcnt_q;
      case (state_q)
         IDLE: begin
            if (addr_load) cnt_d = start_addr;
            if (in_valid) begin
               sel_d   = ImmSel;
               imm_d   = ImmVal;
               base_d  = Base;
               state_d = ENCODE;
            end
         end
         ENCODE: begin
            // Rejected requests leave the last written word on wr_data
            if (legal) begin
               data_d  = enc;
               state_d = WRITE;
            end else begin
               state_d = FAULT;
            end
         end
         WRITE: begin
            cnt_d   = cnt_q + 1'b1;
            state_d = IDLE;
         end
         FAULT: begin
            if (errcnt_q != '1) errcnt_d = errcnt_q + 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         imm_q    <= '0;
         base_q   <= '0;
         data_q   <= '0;
         cnt_q    <= '0;
         errcnt_q <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         imm_q    <= imm_d;
         base_q   <= base_d;
         data_q   <= data_d;
         cnt_q    <= cnt_d;
         errcnt_q <= errcnt_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign wr_en     = (state_q == WRITE);
   assign err       = (state_q == FAULT);
   assign wr_addr   = cnt_q;
   assign wr_data   = data_q;
   assign err_count = errcnt_q;

endmodule
